// File: rtl/ifmap_stream_writer.sv
// ifmap_stream_writer: takes raw ifmap words over valid/ready, tags each one
// with row start/end flags and writes {start, end, data} into the ifmap
// circular buffer at one word per cycle, throttled by the buffer's full flag.
module ifmap_stream_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int ROW_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [ROW_WIDTH-1:0]  num_rows,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  input  logic                  buf_full,
  output logic                  buf_write_en,
  output logic [DATA_WIDTH+1:0] buf_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_t;

  state_t               state_reg;
  logic [LEN_WIDTH-1:0] word_cnt_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [ROW_WIDTH-1:0] row_cnt_reg;
  logic [ROW_WIDTH-1:0] rows_reg;

  logic in_stream;
  logic fire;
  logic first_word;
  logic last_word;
  logic last_row;

  // Tags depend only on the position counters, so idle source cycles or
  // buffer stalls never shift the framing.
  assign in_stream  = (state_reg == STREAM);
  assign first_word = (word_cnt_reg == '0);
  assign last_word  = (word_cnt_reg == len_reg - LEN_WIDTH'(1));
  assign last_row   = (row_cnt_reg == rows_reg - ROW_WIDTH'(1));

  // Zero-latency pass-through: the source word goes straight to the buffer
  // in the cycle it is accepted.
  assign src_ready    = in_stream && !buf_full;
  assign fire         = src_ready && src_valid;
  assign buf_write_en = fire;
  assign buf_data     = in_stream ? {first_word, last_word, src_data} : '0;
  assign busy         = in_stream;
  assign done         = (state_reg == FINISH);

  // Control FSM: latch the transfer geometry on start, walk word/row
  // counters on every accepted word, and pulse done once at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
      row_cnt_reg  <= '0;
      len_reg      <= '0;
      rows_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg      <= row_len;
            rows_reg     <= num_rows;
            word_cnt_reg <= '0;
            row_cnt_reg  <= '0;
            // An empty transfer still reports completion, just without writes.
            if (row_len == '0 || num_rows == '0) begin
              state_reg <= FINISH;
            end else begin
              state_reg <= STREAM;
            end
          end
        end
        STREAM: begin
          if (fire) begin
            if (last_word) begin
              word_cnt_reg <= '0;
              row_cnt_reg  <= row_cnt_reg + ROW_WIDTH'(1);
              if (last_row) begin
                state_reg <= FINISH;
              end
            end else begin
              word_cnt_reg <= word_cnt_reg + LEN_WIDTH'(1);
            end
          end
        end
        FINISH: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_stream_writer.sv
// Self-checking bench for ifmap_stream_writer: table of transfers checked
// cycle by cycle against a counter-free model, expected buffer words kept in
// a scoreboard queue, plus a hand-written mid-transfer reset sequence.
module tb_ifmap_stream_writer;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] row_len;
  logic [RW-1:0] num_rows;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          buf_full;
  logic          buf_write_en;
  logic [DW+1:0] buf_data;
  logic          busy;
  logic          done;

  int n_compared = 0;
  int n_failed   = 0;

  logic [DW+1:0] exp_q[$];

  typedef struct {
    int          len;
    int          rows;
    int          stall_at;    // word index at which buf_full is raised (-1: never)
    int          stall_n;     // number of full cycles
    bit          gaps;        // randomise src_valid
    int          restart_at;  // word index at which a stray start is pulsed (-1: never)
    logic [15:0] base;        // first data word
    int          exp_writes;
  } vec_t;

  vec_t vecs[8];

  ifmap_stream_writer #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .ROW_WIDTH (RW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .row_len     (row_len),
    .num_rows    (num_rows),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .buf_full    (buf_full),
    .buf_write_en(buf_write_en),
    .buf_data    (buf_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW+1:0] exp_word(input int idx, input int len, input logic [15:0] base);
    logic s;
    logic e;
    logic [15:0] d;
    s = ((idx % len) == 0);
    e = ((idx % len) == len - 1);
    d = base + 16'(idx);
    return {s, e, d};
  endfunction

  task automatic run_xfer(input int t, input vec_t v);
    int total;
    int idx;
    int writes;
    int stall_left;
    int cyc;
    bit restarted;
    bit fire;
    bit fin;
    bit in_stream;
    logic [DW+1:0] exp;
    total      = v.len * v.rows;
    idx        = 0;
    writes     = 0;
    stall_left = v.stall_n;
    cyc        = 0;
    restarted  = 0;
    fin        = 0;

    @(posedge clk); #1;
    start     = 1'b1;
    row_len   = LW'(v.len);
    num_rows  = RW'(v.rows);
    src_valid = 1'b1;
    src_data  = v.base;
    buf_full  = 1'b0;
    @(posedge clk); #1;
    start    = 1'b0;
    row_len  = '0;
    num_rows = '0;
    if (total > 0) exp_q.push_back(exp_word(0, v.len, v.base));

    while (!fin && cyc < 300) begin
      buf_full = (idx == v.stall_at) && (stall_left > 0);
      if (buf_full) stall_left--;
      src_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.restart_at == idx && !restarted && idx < total) begin
        start     = 1'b1;
        row_len   = 2;
        num_rows  = 1;
        restarted = 1;
      end

      @(negedge clk);
      in_stream = (idx < total);
      check("busy", busy, in_stream);
      check("src_ready", src_ready, in_stream && !buf_full);
      check("buf_write_en", buf_write_en, in_stream && src_valid && !buf_full);
      check("done", done, idx == total);
      fire = buf_write_en;
      if (buf_write_en) begin
        writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("buf_data", buf_data, exp);
        end
        $display("xfer %0d: write #%0d buf_data=0x%05h", t, writes, buf_data);
      end
      if (idx == total) fin = 1;

      @(posedge clk); #1;
      start    = 1'b0;
      row_len  = '0;
      num_rows = '0;
      if (fire) begin
        idx++;
        if (idx < total) exp_q.push_back(exp_word(idx, v.len, v.base));
        src_data = v.base + 16'(idx);
      end
      cyc++;
    end
    if (!fin) check("timeout", 1, 0);

    buf_full  = 1'b0;
    src_valid = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("write_count", writes, v.exp_writes);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("xfer %0d: len=%0d rows=%0d writes=%0d", t, v.len, v.rows, writes);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{len: 4, rows: 1, stall_at: -1, stall_n: 0, gaps: 0, restart_at: -1, base: 16'h0001, exp_writes: 4};
    vecs[1] = '{len: 3, rows: 2, stall_at: -1, stall_n: 0, gaps: 0, restart_at: -1, base: 16'h000A, exp_writes: 6};
    vecs[2] = '{len: 1, rows: 3, stall_at: -1, stall_n: 0, gaps: 0, restart_at: -1, base: 16'h0100, exp_writes: 3};
    vecs[3] = '{len: 4, rows: 1, stall_at: 1,  stall_n: 5, gaps: 0, restart_at: -1, base: 16'h0001, exp_writes: 4};
    vecs[4] = '{len: 4, rows: 0, stall_at: -1, stall_n: 0, gaps: 0, restart_at: -1, base: 16'h0000, exp_writes: 0};
    vecs[5] = '{len: 0, rows: 3, stall_at: -1, stall_n: 0, gaps: 0, restart_at: -1, base: 16'h0000, exp_writes: 0};
    vecs[6] = '{len: 8, rows: 2, stall_at: -1, stall_n: 0, gaps: 0, restart_at: 5,  base: 16'h1000, exp_writes: 16};
    vecs[7] = '{len: 5, rows: 2, stall_at: 3,  stall_n: 2, gaps: 1, restart_at: -1, base: 16'hBEE0, exp_writes: 10};

    rst       = 1'b1;
    start     = 1'b0;
    row_len   = '0;
    num_rows  = '0;
    src_valid = 1'b0;
    src_data  = '0;
    buf_full  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_buf_write_en", buf_write_en, 0);
    check("rst_buf_data", buf_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    src_valid = 1'b1;
    #1;
    check("idle_src_ready", src_ready, 0);
    check("idle_buf_write_en", buf_write_en, 0);
    src_valid = 1'b0;

    for (int i = 0; i < 8; i++) run_xfer(i, vecs[i]);

    // Reset in the middle of a row: outputs must drop without waiting for a clock.
    @(posedge clk); #1;
    start     = 1'b1;
    row_len   = 4;
    num_rows  = 1;
    src_valid = 1'b1;
    src_data  = 16'h0055;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_write_en", buf_write_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_src_ready", src_ready, 0);
    check("async_rst_buf_write_en", buf_write_en, 0);
    check("async_rst_buf_data", buf_data, 0);
    check("async_rst_done", done, 0);
    $display("reset mid-row: busy=%0b write_en=%0b buf_data=0x%05h", busy, buf_write_en, buf_data);
    @(posedge clk); #1;
    rst       = 1'b0;
    src_valid = 1'b0;

    run_xfer(8, '{len: 2, rows: 1, stall_at: -1, stall_n: 0, gaps: 0, restart_at: -1, base: 16'h0077, exp_writes: 2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
